alu_multicycle: RTL

// - Parametrised, clocked successor to the combinational 8-bit ALU: same opcode map, same 7-bit Flags layout.
// - Logic, add, sub and shift ops complete in 1 cycle; MUL (shift-add) and DIV/MOD (restoring) take WIDTH iterations.
// - Sits between register file and writeback; the control FSM issues ops with start and waits for done.

---
 rtl/alu_multicycle.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: clocked ALU with the classic 8-bit opcode map and 7-bit Flags.
// Logic/add/sub/shift ops finish in one cycle. MUL (shift-add) and DIV/MOD
// (restoring) run WIDTH iterations.
// Handshake: start is accepted only while the FSM is IDLE. busy is high from the
// cycle after acceptance until done. done is a one-cycle pulse, and
// operation_result/Flags are valid from that cycle and held until the next done.
// Optional feature: define ALU_WIDE_RESULT_EN to add the result_hi port.
// fsm_state_o exposes the control state for observation.
module alu_multicycle #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [SEL_W-1:0] ALU_sel,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] operation_result,
   output logic [6:0]       Flags,
`ifdef ALU_WIDE_RESULT_EN
   output logic [WIDTH-1:0] result_hi,
`endif
   output logic [1:0]       fsm_state_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(8'h01);
   localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(8'h02);
   localparam logic [SEL_W-1:0] OP_MUL  = SEL_W'(8'h03);
   localparam logic [SEL_W-1:0] OP_DIV  = SEL_W'(8'h04);
   localparam logic [SEL_W-1:0] OP_INC  = SEL_W'(8'h05);
   localparam logic [SEL_W-1:0] OP_DEC  = SEL_W'(8'h06);
   localparam logic [SEL_W-1:0] OP_MOD  = SEL_W'(8'h07);
   localparam logic [SEL_W-1:0] OP_SHL  = SEL_W'(8'h08);
   localparam logic [SEL_W-1:0] OP_SHR  = SEL_W'(8'h09);
   localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(8'h0A);
   localparam logic [SEL_W-1:0] OP_NAND = SEL_W'(8'h0B);
   localparam logic [SEL_W-1:0] OP_NOR  = SEL_W'(8'h0D);
   localparam logic [SEL_W-1:0] OP_NOT  = SEL_W'(8'h0E);
   localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(8'h0F);
   localparam logic [SEL_W-1:0] OP_XNOR = SEL_W'(8'h10);
   localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(8'h11);
   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q;
   logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, hi_d, lo_d;
   logic [CW-1:0]    cnt_q;
   logic             accept, iter_op, last_iter;
   logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
   logic [WIDTH:0]   add_w, sub_w;
   logic [WIDTH-1:0] res_d, res_q;
   logic [6:0]       flags_d, flags_q;
   logic             c_d, ov_d, dir_d, done_q;

   assign accept    = (state_q == S_IDLE) && start;
   assign iter_op   = (ALU_sel == OP_MUL) ||
                      (((ALU_sel == OP_DIV) || (ALU_sel == OP_MOD)) && (operand2 != '0));
   assign last_iter = (cnt_q == CW'(WIDTH - 1));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: iterative ops go through EXEC, everything else straight to DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = iter_op ? S_EXEC : S_DONE;
         S_EXEC: if (last_iter) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // One MUL/DIV step: hi:lo holds partial product, or remainder:quotient
   always_comb begin
      mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      rem_sh  = {hi_q, lo_q[WIDTH-1]};
      rem_sub = rem_sh - {1'b0, b_q};
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (sel_q == OP_MUL) begin
         hi_d = mul_sum[WIDTH:1];
         lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
      end else if (rem_sh >= {1'b0, b_q}) begin
         hi_d = rem_sub[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
         hi_d = rem_sh[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
   end

   // Operand latch at acceptance and iteration datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q <= '0; a_q <= '0; b_q <= '0; cnt_q <= '0; hi_q <= '0; lo_q <= '0;
      end else if (accept) begin
         sel_q <= ALU_sel; a_q <= operand1; b_q <= operand2;
         cnt_q <= '0; hi_q <= '0; lo_q <= operand1;
      end else if (state_q == S_EXEC) begin
         if (!last_iter) cnt_q <= cnt_q + CW'(1);
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   // Output logic: busy flag plus result/flag computation from latched operands
   always_comb begin
      busy  = (state_q != S_IDLE);
      add_w = {1'b0, a_q} + {1'b0, b_q};
      sub_w = {1'b0, a_q} - {1'b0, b_q};
      res_d = '0;
      c_d   = 1'b0;
      ov_d  = 1'b0;
      dir_d = 1'b0;
      case (sel_q)
         OP_ADD: begin
            res_d = add_w[WIDTH-1:0];
            c_d   = add_w[WIDTH];
            ov_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            res_d = sub_w[WIDTH-1:0];
            c_d   = sub_w[WIDTH];
            ov_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_MUL: begin
            res_d = lo_q;
            ov_d  = (hi_q != '0);
         end
         OP_DIV: begin
            res_d = (b_q == '0) ? '1 : lo_q;
            ov_d  = (b_q == '0);
         end
         OP_MOD: begin
            res_d = (b_q == '0) ? a_q : hi_q;
            ov_d  = (b_q == '0);
         end
         OP_INC: begin
            res_d = a_q + WIDTH'(1);
            c_d   = (a_q == '1);
            ov_d  = (a_q == MAX_POS);
         end
         OP_DEC: begin
            res_d = a_q - WIDTH'(1);
            c_d   = (a_q == '0);
            ov_d  = (a_q == MIN_NEG);
         end
         OP_SHL: begin
            res_d = {a_q[WIDTH-2:0], 1'b0};
            c_d   = a_q[WIDTH-1];
            ov_d  = a_q[WIDTH-1] ^ a_q[WIDTH-2];
            dir_d = 1'b1;
         end
         OP_SHR: begin
            res_d = {1'b0, a_q[WIDTH-1:1]};
            c_d   = a_q[0];
         end
         OP_AND:  res_d = a_q & b_q;
         OP_NAND: res_d = ~(a_q & b_q);
         OP_NOR:  res_d = ~(a_q | b_q);
         OP_NOT:  res_d = ~a_q;
         OP_OR:   res_d = a_q | b_q;
         OP_XNOR: res_d = ~(a_q ^ b_q);
         OP_XOR:  res_d = a_q ^ b_q;
         default: res_d = '0;
      endcase
      flags_d = {ov_d, dir_d, 1'b0, ~^res_d, res_d[WIDTH-1], c_d, (res_d == '0)};
   end

   // Result registers: load and pulse done on the DONE -> IDLE edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_q  <= 1'b0;
         res_q   <= '0;
         flags_q <= '0;
      end else begin
         done_q <= (state_q == S_DONE);
         if (state_q == S_DONE) begin
            res_q   <= res_d;
            flags_q <= flags_d;
         end
      end
   end

`ifdef ALU_WIDE_RESULT_EN
   logic [WIDTH-1:0] rhi_d, rhi_q;

   // Second result half: MUL high product, DIV remainder, MOD quotient
   always_comb begin
      case (sel_q)
         OP_MUL:  rhi_d = hi_q;
         OP_DIV:  rhi_d = (b_q == '0) ? a_q : hi_q;
         OP_MOD:  rhi_d = (b_q == '0) ? '1 : lo_q;
         default: rhi_d = '0;
      endcase
   end

   // Second result half register, updated together with done
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   rhi_q <= '0;
      else if (state_q == S_DONE)  rhi_q <= rhi_d;
   end

   assign result_hi = rhi_q;
`endif

   assign done             = done_q;
   assign operation_result = res_q;
   assign Flags            = flags_q;
   assign fsm_state_o      = state_q;

endmodule
